// File: rtl/entry_handler.sv
// ---------------------------------------------------------------------------
// entry_handler -- producer side of the digit-entry interface.
//
// Conditions the raw active-low enter key (2-flop synchronizer + debounce),
// validates the BCD digit on the switches, writes accepted digits into a
// 4-slot code register and pulses the external digit counter once per digit.
// After the fourth digit it pulses code_ready and parks in DONE until a
// restart or reset.
//
// Ports:
//   clk                     system clock
//   sys_reset               synchronous active-high global reset
//   restart_pulse           one-cycle restart of the current attempt
//   enter_key_n             raw asynchronous enter key, 0 = pressed
//   digit_sw[3:0]           digit to enter
//   digit_count[2:0]        current count from the digit counter (0..4)
//   full4                   digit counter holds 4
//   increment_counter_pulse one-cycle request to the digit counter
//   entry_code[15:0]        entered digits, first digit in [15:12]
//   code_ready              one-cycle pulse, four digits captured
//   invalid_digit           one-cycle pulse, press with digit_sw > 9
//   busy                    high in INC, SETTLE and DONE
//   last_digit[3:0]         (LAST_DIGIT_EN only) echo of last accepted digit
//
// Optional feature macro: LAST_DIGIT_EN adds the last_digit output.
// ---------------------------------------------------------------------------
module entry_handler #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        sys_reset,
  input  logic        restart_pulse,
  input  logic        enter_key_n,
  input  logic [3:0]  digit_sw,
  input  logic [2:0]  digit_count,
  input  logic        full4,
  output logic        increment_counter_pulse,
  output logic [15:0] entry_code,
  output logic        code_ready,
  output logic        invalid_digit,
  output logic        busy
`ifdef LAST_DIGIT_EN
  ,
  output logic [3:0]  last_digit
`endif
);

  localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, INC, SETTLE, DONE} state_e;

  // input conditioning
  logic             sync1_q, sync1_d;
  logic             key_sync_q, key_sync_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic             key_stable_q, key_stable_d;
  logic             key_prev_q, key_prev_d;
  logic [1:0]       fill_q, fill_d;
  logic             armed_q, armed_d;
  logic             press_evt;

  // control
  state_e           state_q, state_d;
  logic [15:0]      entry_code_q, entry_code_d;
  logic             inc_q, inc_d;
  logic             ready_q, ready_d;
  logic             inv_q, inv_d;
  logic             busy_q, busy_d;
  logic             full_now;
  logic [3:0]       slot_msb;
`ifdef LAST_DIGIT_EN
  logic [3:0]       last_q, last_d;
`endif

  // -------------------------------------------------------------------------
  // Synchronizer, debounce and press detection
  // -------------------------------------------------------------------------
  always_comb begin
    sync1_d      = ~enter_key_n;
    key_sync_d   = sync1_q;
    key_prev_d   = key_stable_q;
    // fill_q[1] marks that key_sync_q holds a real sample, not the reset value
    fill_d       = {fill_q[0], 1'b1};
    // Arm only after the key has been seen released since reset, so a key
    // held through reset never yields a press.
    armed_d      = armed_q | (fill_q[1] & ~key_sync_q);
    key_stable_d = key_stable_q;
    db_cnt_d     = '0;
    if (key_sync_q != key_stable_q) begin
      if (db_cnt_q == CNT_MAX) key_stable_d = key_sync_q;
      else                     db_cnt_d     = db_cnt_q + CNT_W'(1);
    end
    press_evt = key_stable_q & ~key_prev_q & armed_q;
  end

  // -------------------------------------------------------------------------
  // Entry FSM and registered outputs
  // -------------------------------------------------------------------------
  always_comb begin
    // A count of 4 is treated as full even if full4 disagrees, so slot 4
    // can never be addressed.
    full_now     = full4 | digit_count[2];
    slot_msb     = 4'd15 - {digit_count[1:0], 2'b00};
    state_d      = state_q;
    entry_code_d = entry_code_q;
    inc_d        = 1'b0;
    ready_d      = 1'b0;
    inv_d        = 1'b0;
`ifdef LAST_DIGIT_EN
    last_d       = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (press_evt && !full_now) begin
          if (digit_sw > 4'd9) begin
            inv_d = 1'b1;
          end else begin
            entry_code_d[slot_msb -: 4] = digit_sw;
`ifdef LAST_DIGIT_EN
            last_d = digit_sw;
`endif
            inc_d   = 1'b1;
            state_d = INC;
          end
        end
      end
      INC:    state_d = SETTLE;
      // counter has absorbed the pulse by now, so full4 is current
      SETTLE: begin
        if (full4) begin
          state_d = DONE;
          ready_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      DONE:   state_d = DONE;
      default: state_d = IDLE;
    endcase

    // restart beats any same-cycle press; it leaves key conditioning alone
    if (restart_pulse) begin
      state_d      = IDLE;
      entry_code_d = '0;
      inc_d        = 1'b0;
      ready_d      = 1'b0;
      inv_d        = 1'b0;
`ifdef LAST_DIGIT_EN
      last_d       = '0;
`endif
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (sys_reset) begin
      sync1_q      <= 1'b0;
      key_sync_q   <= 1'b0;
      db_cnt_q     <= '0;
      key_stable_q <= 1'b0;
      key_prev_q   <= 1'b0;
      fill_q       <= '0;
      armed_q      <= 1'b0;
      state_q      <= IDLE;
      entry_code_q <= '0;
      inc_q        <= 1'b0;
      ready_q      <= 1'b0;
      inv_q        <= 1'b0;
      busy_q       <= 1'b0;
`ifdef LAST_DIGIT_EN
      last_q       <= '0;
`endif
    end else begin
      sync1_q      <= sync1_d;
      key_sync_q   <= key_sync_d;
      db_cnt_q     <= db_cnt_d;
      key_stable_q <= key_stable_d;
      key_prev_q   <= key_prev_d;
      fill_q       <= fill_d;
      armed_q      <= armed_d;
      state_q      <= state_d;
      entry_code_q <= entry_code_d;
      inc_q        <= inc_d;
      ready_q      <= ready_d;
      inv_q        <= inv_d;
      busy_q       <= busy_d;
`ifdef LAST_DIGIT_EN
      last_q       <= last_d;
`endif
    end
  end

  assign increment_counter_pulse = inc_q;
  assign entry_code              = entry_code_q;
  assign code_ready              = ready_q;
  assign invalid_digit           = inv_q;
  assign busy                    = busy_q;
`ifdef LAST_DIGIT_EN
  assign last_digit              = last_q;
`endif

endmodule

// File: tb/tb_entry_handler.sv
// Bench for entry_handler with DEBOUNCE_CYCLES=4. A behavioural model (key
// sample history, run length of disagreeing samples, digit list and a
// cycles-since-accept counter) predicts every output each cycle; a digit
// counter model answers the increment pulses.
module tb_entry_handler;
  localparam int DB = 4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        sys_reset, restart_pulse, enter_key_n, full4;
  logic [3:0]  digit_sw;
  logic [2:0]  digit_count;
  logic        increment_counter_pulse, code_ready, invalid_digit, busy;
  logic [15:0] entry_code;
`ifdef LAST_DIGIT_EN
  logic [3:0]  last_digit;
`endif

  entry_handler #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .sys_reset(sys_reset), .restart_pulse(restart_pulse),
    .enter_key_n(enter_key_n), .digit_sw(digit_sw), .digit_count(digit_count),
    .full4(full4), .increment_counter_pulse(increment_counter_pulse),
    .entry_code(entry_code), .code_ready(code_ready),
    .invalid_digit(invalid_digit), .busy(busy)
`ifdef LAST_DIGIT_EN
    , .last_digit(last_digit)
`endif
  );

  int total = 0, bad = 0;
  int cyc = 0, n_inc = 0, n_rdy = 0, n_inv = 0, n_busy = 0;
  int last_inc_cyc = 0, last_rdy_cyc = 0;
  logic prev_inc_obs = 1'b0;

  // model state: -1 in the sample history stands for a reset-cleared sample
  int   m_pipe[$];
  int   m_run, m_since, m_cnt;
  bit   m_stable, m_rise, m_armed, m_done;
  logic [15:0] e_code;
  logic [3:0]  e_last;
  logic        e_inc, e_rdy, e_inv, e_busy;

  task automatic chk(string tag, logic [15:0] got, logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  // advance the model by one edge, clock the DUT, then compare everything
  task automatic tick();
    bit ev, sync_now;
    int base;
    sync_now = (m_pipe[0] == 1);
    if (sys_reset) begin
      m_pipe.delete(); m_pipe.push_back(-1); m_pipe.push_back(-1);
      m_run = 0; m_stable = 0; m_rise = 0; m_armed = 0;
      m_since = 0; m_done = 0; m_cnt = 0;
      e_code = '0; e_last = '0; e_inc = 0; e_rdy = 0; e_inv = 0; e_busy = 0;
    end else begin
      ev = m_rise && m_armed;
      if (m_pipe[0] == 0) m_armed = 1;
      m_rise = 0;
      if (sync_now != m_stable) begin
        m_run++;
        if (m_run == DB) begin
          m_stable = sync_now; m_run = 0; m_rise = sync_now;
        end
      end else begin
        m_run = 0;
      end
      m_pipe.push_back(enter_key_n ? 0 : 1);
      void'(m_pipe.pop_front());
      if (restart_pulse) begin
        m_since = 0; m_done = 0; m_cnt = 0;
        e_code = '0; e_last = '0; e_inc = 0; e_rdy = 0; e_inv = 0; e_busy = 0;
      end else begin
        if (e_inc && m_cnt < 4) m_cnt++;
        e_inc = 0; e_rdy = 0; e_inv = 0;
        if (m_since == 1) m_since = 2;
        else if (m_since == 2) begin
          m_since = 0;
          if (full4) begin m_done = 1; e_rdy = 1; end
        end else if (!m_done && ev && !full4) begin
          if (digit_sw > 4'd9) e_inv = 1;
          else begin
            base = 15 - 4 * int'(digit_count);
            e_code[base -: 4] = digit_sw;
            e_last = digit_sw;
            m_since = 1; e_inc = 1;
          end
        end
        e_busy = (m_since != 0) || m_done;
      end
    end

    @(posedge clk); #1; cyc++;
    digit_count = 3'(m_cnt);
    full4       = (m_cnt == 4);
    if (increment_counter_pulse === 1'b1) begin n_inc++; last_inc_cyc = cyc; end
    if (code_ready === 1'b1) begin n_rdy++; last_rdy_cyc = cyc; end
    if (invalid_digit === 1'b1) n_inv++;
    if (busy === 1'b1) n_busy++;
    chk("inc", 16'(increment_counter_pulse), 16'(e_inc));
    chk("code", entry_code, e_code);
    chk("ready", 16'(code_ready), 16'(e_rdy));
    chk("invalid", 16'(invalid_digit), 16'(e_inv));
    chk("busy", 16'(busy), 16'(e_busy));
`ifdef LAST_DIGIT_EN
    chk("last_digit", 16'(last_digit), 16'(e_last));
`endif
    chk("inc_back_to_back", 16'(prev_inc_obs & increment_counter_pulse), 16'd0);
    prev_inc_obs = increment_counter_pulse;
  endtask

  task automatic cycles(int n);
    repeat (n) tick();
  endtask

  task automatic press(logic [3:0] d, int hold, int rel);
    digit_sw = d;
    enter_key_n = 1'b0; cycles(hold);
    enter_key_n = 1'b1; cycles(rel);
  endtask

  task automatic do_restart();
    restart_pulse = 1'b1; tick(); restart_pulse = 1'b0;
  endtask

  int i0, r0, v0, b0;

  initial begin
    sys_reset = 1'b1; restart_pulse = 1'b0; enter_key_n = 1'b0;
    digit_sw = 4'd5; digit_count = '0; full4 = 1'b0;

    // reset with key held down, then keep it held: no press may appear
    cycles(2);
    chk("rst_code", entry_code, 16'h0000);
    chk("rst_outs", 16'({increment_counter_pulse, code_ready, invalid_digit, busy}), 16'd0);
    sys_reset = 1'b0;
    cycles(20);
    chk("rst_held_no_press", 16'(n_inc), 16'd0);
    enter_key_n = 1'b1; cycles(10);
    press(4'd5, 10, 10);
    chk("rst_repress", entry_code, 16'h5000);
    chk("rst_repress_inc", 16'(n_inc), 16'd1);

    // single press of 7
    do_restart();
    i0 = n_inc; n_busy = 0;
    press(4'd7, 10, 10);
    chk("single_code", entry_code, 16'h7000);
    chk("single_inc", 16'(n_inc - i0), 16'd1);
    chk("single_busy_len", 16'(n_busy), 16'd2);

    // full code 1-2-3-4, then a fifth press that must be ignored
    do_restart();
    i0 = n_inc; r0 = n_rdy;
    press(4'd1, 10, 8); press(4'd2, 10, 8); press(4'd3, 10, 8); press(4'd4, 10, 8);
    chk("full_code", entry_code, 16'h1234);
    chk("full_inc", 16'(n_inc - i0), 16'd4);
    chk("full_ready", 16'(n_rdy - r0), 16'd1);
    chk("full_ready_lat", 16'(last_rdy_cyc - last_inc_cyc), 16'd2);
    press(4'd5, 10, 8);
    chk("fifth_no_inc", 16'(n_inc - i0), 16'd4);
    chk("fifth_code", entry_code, 16'h1234);
    chk("done_busy", 16'(busy), 16'd1);

    // restart out of DONE, then a fresh digit
    do_restart();
    chk("restart_code", entry_code, 16'h0000);
    chk("restart_busy", 16'(busy), 16'd0);
    press(4'd9, 10, 10);
    chk("restart_9", entry_code, 16'h9000);

    // invalid digit leaves the code alone
    i0 = n_inc; v0 = n_inv;
    press(4'hB, 10, 10);
    chk("inv_pulse", 16'(n_inv - v0), 16'd1);
    chk("inv_no_inc", 16'(n_inc - i0), 16'd0);
    chk("inv_code", entry_code, 16'h9000);

    // bounce: toggle every 2 cycles for 20 cycles, then hold down
    i0 = n_inc; digit_sw = 4'd3;
    for (int k = 0; k < 10; k++) begin
      enter_key_n = k[0]; cycles(2);
    end
    enter_key_n = 1'b0; cycles(12);
    enter_key_n = 1'b1; cycles(10);
    chk("bounce_one_press", 16'(n_inc - i0), 16'd1);
    chk("bounce_code", entry_code, 16'h9300);

    // randomized presses, bounces, restarts and the odd reset
    for (int it = 0; it < 60; it++) begin
      digit_sw = 4'($urandom_range(0, 15));
      b0 = $urandom_range(0, 3);
      for (int k = 0; k < b0; k++) begin
        enter_key_n = 1'b0; tick(); enter_key_n = 1'b1; tick();
      end
      enter_key_n = 1'b0; cycles($urandom_range(1, 12));
      enter_key_n = 1'b1; cycles($urandom_range(1, 12));
      if ($urandom_range(0, 7) == 0) do_restart();
      if ($urandom_range(0, 29) == 0) begin
        sys_reset = 1'b1; enter_key_n = 1'($urandom_range(0, 1));
        cycles(2); sys_reset = 1'b0; cycles(4); enter_key_n = 1'b1; cycles(4);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
